// File: rtl/sys_reset_ctrl.sv
// ---------------------------------------------------------------------------
// SysResetCtrl (module sys_reset_ctrl)
//
// Purpose: sequences the active-low reset of the timer core. A reset sequence
// is HOLD for HOLD_CYCLES cycles followed by a single RELEASE cycle, then the
// core comes out of reset. Sequences are started by the block reset, by an
// asynchronous external request (after synchronization) or by a four-phase
// software request/acknowledge handshake.
//
// Parameters:
//    HOLD_CYCLES  core reset hold length in sys_clk cycles (1..255)
//    SYNC_STAGES  depth of the ext_resetn synchronizer (2..4)
//
// Ports:
//    sys_clk      in   single clock, everything on its rising edge
//    sys_reset    in   asynchronous active-high block reset
//    ext_resetn   in   asynchronous active-low external reset request
//    sw_rst_req   in   level software reset request
//    cause_clr    in   one-cycle clear of rst_cause
//    core_resetn  out  registered active-low reset to the timer core
//    rst_busy     out  high while a reset sequence is in progress
//    sw_rst_ack   out  software request acknowledge
//    rst_cause    out  sticky cause, bit0 = external, bit1 = software
//
// Build option: define SYS_RESET_CTRL_CAUSE_EN to include the sticky cause
// register; without it rst_cause reads 00 and cause_clr has no effect.
// ---------------------------------------------------------------------------
module sys_reset_ctrl #(
   parameter int HOLD_CYCLES = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       sys_reset,
   input  logic       ext_resetn,
   input  logic       sw_rst_req,
   input  logic       cause_clr,
   output logic       core_resetn,
   output logic       rst_busy,
   output logic       sw_rst_ack,
   output logic [1:0] rst_cause
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] syncChain_q;
   logic                   extReq;
   logic                   swAccept;

   state_t     state_q, state_d;
   logic [7:0] holdCount_q, holdCount_d;
   logic       swPending_q, swPending_d;
   logic       coreResetn_q, coreResetn_d;
   logic       busy_q, busy_d;
   logic       ack_q, ack_d;

   // The external request is asynchronous, so it is pulled through a chain of
   // flops that idle at 1 (no request); the request is the inverted last stage.
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         syncChain_q <= '1;
      end else begin
         syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], ext_resetn};
      end
   end

   assign extReq = ~syncChain_q[SYNC_STAGES-1];

   // A software request only counts once the previous one has been fully
   // acknowledged and withdrawn, which keeps one level request from
   // retriggering a second sequence.
   assign swAccept = sw_rst_req & ~ack_q;

   // State register plus the registered outputs. Block reset parks the FSM in
   // HOLD with a cleared counter so deassertion runs a normal full sequence,
   // and it drops any software request that was in flight.
   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         state_q      <= HOLD;
         holdCount_q  <= 8'd0;
         swPending_q  <= 1'b0;
         coreResetn_q <= 1'b0;
         busy_q       <= 1'b1;
         ack_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         holdCount_q  <= holdCount_d;
         swPending_q  <= swPending_d;
         coreResetn_q <= coreResetn_d;
         busy_q       <= busy_d;
         ack_q        <= ack_d;
      end
   end

   // Next-state logic. In HOLD a still-active external request keeps pulling
   // the counter back to zero, so the core stays in reset until the request
   // has been gone for a full hold period. Software requests are ignored
   // while a sequence is running; swPending remembers whether the running
   // sequence owes the software side an acknowledge.
   always_comb begin
      state_d     = state_q;
      holdCount_d = holdCount_q;
      swPending_d = swPending_q;
      case (state_q)
         IDLE: begin
            if (extReq || swAccept) begin
               state_d     = HOLD;
               holdCount_d = 8'd0;
               swPending_d = swAccept;
            end
         end
         HOLD: begin
            if (extReq) begin
               holdCount_d = 8'd0;
            end else if (holdCount_q == HoldLast) begin
               state_d = RELEASE;
            end else begin
               holdCount_d = holdCount_q + 8'd1;
            end
         end
         RELEASE: begin
            state_d     = IDLE;
            swPending_d = 1'b0;
         end
         default: begin
            state_d     = HOLD;
            holdCount_d = 8'd0;
            swPending_d = 1'b0;
         end
      endcase
   end

   // Output logic. The reset and busy outputs are derived from the next state
   // so that, once registered, they change on the same edge as the state.
   // The acknowledge rises as the sequence finishes and falls once the
   // request has been withdrawn while idle.
   always_comb begin
      coreResetn_d = (state_d == IDLE);
      busy_d       = (state_d != IDLE);
      ack_d        = ack_q;
      if (state_q == RELEASE && swPending_q) begin
         ack_d = 1'b1;
      end else if (state_q == IDLE && !sw_rst_req) begin
         ack_d = 1'b0;
      end
   end

   assign core_resetn = coreResetn_q;
   assign rst_busy    = busy_q;
   assign sw_rst_ack  = ack_q;

`ifdef SYS_RESET_CTRL_CAUSE_EN
   logic [1:0] cause_q, cause_d;
   logic [1:0] causeSet;

   // Cause bits latch on the edge that leaves IDLE, one per source that took
   // part in the trigger. The clear is applied first so a set in the same
   // cycle survives it.
   assign causeSet = {swAccept, extReq} & {2{state_q == IDLE}};

   always_comb begin
      cause_d = cause_clr ? 2'b00 : cause_q;
      cause_d = cause_d | causeSet;
   end

   always_ff @(posedge sys_clk or posedge sys_reset) begin
      if (sys_reset) begin
         cause_q <= 2'b00;
      end else begin
         cause_q <= cause_d;
      end
   end

   assign rst_cause = cause_q;
`else
   logic unusedCauseClr;

   // Without the cause register the clear input has nothing to act on.
   assign unusedCauseClr = cause_clr;
   assign rst_cause      = 2'b00;
`endif

endmodule

// File: doc/sys_reset_ctrl.md
SYS_RESET_CTRL -- requirements
Module: sys_reset_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: core reset hold length in sys_clk cycles, legal range 1..255.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: ext_resetn synchronizer depth, legal range 2..4.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port sys_reset, input, 1 bit: asynchronous, active-high block reset.
REQ-005 SHALL have port ext_resetn, input, 1 bit: asynchronous, active-low external reset request.
REQ-006 SHALL have port sw_rst_req, input, 1 bit: synchronous, level software reset request (four-phase with sw_rst_ack).
REQ-007 SHALL have port cause_clr, input, 1 bit: synchronous one-cycle clear of rst_cause.
REQ-008 SHALL have port core_resetn, output, 1 bit: registered active-low reset to the timer core.
REQ-009 SHALL have port rst_busy, output, 1 bit: high while a reset sequence is in progress.
REQ-010 SHALL have port sw_rst_ack, output, 1 bit: software request acknowledge.
REQ-011 SHALL have port rst_cause, output, 2 bits: sticky cause, bit0 = external, bit1 = software.

Function
REQ-012 SHALL pass ext_resetn through SYNC_STAGES flops, each reset to 1; ext_req is the inverted last stage.
REQ-013 SHALL implement FSM states IDLE, HOLD and RELEASE, plus an 8-bit hold counter.
REQ-014 HOLD: counter increments each cycle; counter == HOLD_CYCLES-1 -> RELEASE.
REQ-015 HOLD: ext_req high clears counter to 0 and stays in HOLD (stretch); sw_rst_req is ignored.
REQ-016 RELEASE: unconditional -> IDLE after one cycle.
REQ-017 IDLE: ext_req high, or sw_rst_req high with sw_rst_ack low -> HOLD with counter cleared.
REQ-018 core_resetn SHALL be 0 in HOLD and RELEASE and 1 in IDLE, registered so it changes on the same edge as the state.
REQ-019 Latency: trigger sampled at edge N -> core_resetn 0 after edge N -> core_resetn 1 after edge N+HOLD_CYCLES+1 (no stretch).
REQ-020 rst_busy SHALL be registered and equal (state != IDLE).
REQ-021 sw_rst_ack SHALL set on the RELEASE->IDLE edge of a sequence that included a software trigger.
REQ-022 sw_rst_ack SHALL clear on the edge after sw_rst_req is sampled low in IDLE; a new software request is accepted only once ack is low.
REQ-023 Simultaneous ext_req and sw_rst_req in IDLE: one sequence; both cause bits set; sw_rst_ack handshake still completes.
REQ-024 HOLD_CYCLES=1: HOLD lasts exactly one cycle.

Reset
REQ-025 sys_reset high SHALL asynchronously force: state=HOLD, counter=0, core_resetn=0, rst_busy=1, sw_rst_ack=0, rst_cause=00, synchronizer flops=1.
REQ-026 On sys_reset deassertion, SHALL run a full HOLD/RELEASE sequence identical to REQ-019; core_resetn rises after the (HOLD_CYCLES+1)th edge.
REQ-027 sys_reset asserted mid-sequence or during a handshake SHALL abort it; no ack is issued for the aborted software request.

Configuration
REQ-028 Macro SYS_RESET_CTRL_CAUSE_EN SHALL gate the cause register.
REQ-029 With SYS_RESET_CTRL_CAUSE_EN defined: rst_cause bits set on the IDLE->HOLD trigger edge per source; cause_clr clears both bits; a set wins over a clear in the same cycle.
REQ-030 Without SYS_RESET_CTRL_CAUSE_EN: rst_cause is tied to 00, cause_clr is ignored, and no cause flops exist.

Verification
REQ-031 sys_reset high 40 ns then low, HOLD_CYCLES=4 -> core_resetn=0, rst_busy=1 -> core_resetn rises after the 5th rising edge after deassertion.
REQ-032 IDLE, sw_rst_req=1 -> core_resetn low for 5 cycles -> sw_rst_ack=1 -> drop req -> ack=0 next cycle, rst_cause=10.
REQ-033 ext_resetn low 1 cycle -> core_resetn falls after SYNC_STAGES+1 edges; rst_cause=01; held low 10 cycles -> stretch: release 5 cycles after sync ext_req clears.
REQ-034 sw_rst_req and ext_resetn asserted together -> single sequence, rst_cause=11; cause_clr -> 00; cause_clr coincident with a new set -> set bit survives.
REQ-035 sys_reset pulse during HOLD at counter=2 -> counter restarts at 0, sw_rst_ack stays 0; macro-off build -> rst_cause=00 throughout.
